dbg_scan_dr_engine: RTL and testbench
=====================================

Name: dbg_scan_dr_engine

Overview:
- Parametrised system-clock data-register engine for the CPU debug module.
- Sits behind the JTAG PHY and its clock-domain-crossing logic. Receives single-cycle IR/DR strobes already in the clk domain.
- Captures a per-instruction status word and shifts it out LSB-first while shifting TDI in.
- On update, presents the shifted word on jdo and raises a per-instruction take_action or take_no_action pulse. Generalises the fixed 2-bit IR / 38-bit DR arrangement to N channels.
- Adds two features: detection of short scans (sticky error) and IR-change abort.

Parameters:
- IR_WIDTH, 2, instruction register width; NUM_CH = 2**IR_WIDTH channels.
- DR_WIDTH, 38, data register width.
- ACTION_BIT, 35, jdo bit selecting take_action (1) or take_no_action (0).
- STATUS_IN_MSB, 1, when 1, captured bit DR_WIDTH-1 is replaced by short_scan_err.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ir_in  in  IR_WIDTH  instruction value from the PHY.
- ir_update  in  1  one-cycle pulse: latch ir_in.
- dr_capture  in  1  one-cycle pulse: load capture word.
- dr_shift  in  1  one-cycle pulse per shifted bit.
- tdi  in  1  serial data in, sampled with dr_shift.
- dr_update  in  1  one-cycle pulse: scan complete.
- capture_data  in  NUM_CH*DR_WIDTH  capture word; channel k occupies bits [k*DR_WIDTH +: DR_WIDTH].
- err_clear  in  1  clears short_scan_err.
- tdo  out  1  serial data out, equals sr[0].
- ir_latched  out  IR_WIDTH  current instruction.
- jdo  out  DR_WIDTH  last completed scan word.
- take_action  out  NUM_CH  one-hot, one-cycle pulse.
- take_no_action  out  NUM_CH  one-hot, one-cycle pulse.
- short_scan_err  out  1  sticky short-scan flag.
- busy  out  1  high in LOADED or SHIFTING.

Behaviour:

Reset:
- Asynchronous, immediate.
- sr, jdo, ir_latched, shift_cnt, all pulse outputs, short_scan_err, busy = 0. State = IDLE.

State machine (IDLE, LOADED, SHIFTING):
- IDLE + dr_capture -> LOADED.
  - sr <= channel ir_latched of capture_data.
  - If STATUS_IN_MSB, sr[DR_WIDTH-1] <= short_scan_err.
  - shift_cnt <= 0.
- LOADED or SHIFTING + dr_shift -> SHIFTING.
  - sr <= {tdi, sr[DR_WIDTH-1:1]}.
  - shift_cnt increments, saturating at DR_WIDTH+1.
- LOADED or SHIFTING + dr_update -> IDLE. Outcome depends on shift_cnt:
  - shift_cnt == DR_WIDTH: jdo <= sr. Next cycle, exactly one of take_action[ir_latched] (if sr[ACTION_BIT]=1) or take_no_action[ir_latched] pulses for one cycle. Pulse and new jdo are both visible the cycle after dr_update.
  - shift_cnt == 0: read-only scan; jdo unchanged, no pulse.
  - Any other value (short or over-long): short_scan_err <= 1; jdo unchanged, no pulse.
- dr_update or dr_shift in IDLE: ignored.
- dr_capture in LOADED or SHIFTING: restarts the capture (reload sr, shift_cnt <= 0).

ir_update:
- Any state: ir_latched <= ir_in.
- In LOADED or SHIFTING, also aborts: -> IDLE, no pulse, jdo unchanged, no error.

Priority within one cycle:
- ir_update > dr_update > dr_capture > dr_shift. Lower-priority strobes in the same cycle are dropped.

Error flag:
- err_clear and an error set in the same cycle: set wins.

Output timing:
- tdo is combinational from sr[0], so it is valid the cycle after each capture or shift.
- Pulse outputs are never asserted on two consecutive cycles from a single update.

Decomposition:
- Package dbg_scan_pkg holds:
  - state enum {IDLE, LOADED, SHIFTING};
  - default constants DBG_IR_WIDTH=2, DBG_DR_WIDTH=38, DBG_ACTION_BIT=35.
- One natural sub-module, dbg_scan_action_decode: registered one-hot decoder producing take_action / take_no_action from ir_latched, the action bit, and an update_ok strobe.

Test Plan:
1. Reset asserted mid-SHIFTING after 10 shifts -> all outputs 0 immediately; state IDLE; a following dr_update produces no pulse.
2. ir=2, capture_data ch2=38'h2A_5555_AAAA, 38 shifts with tdi pattern giving 38'h08_0000_0001, then dr_update -> tdo sequence reproduces ch2 LSB-first (bit 37 = short_scan_err=0); jdo=38'h08_0000_0001 next cycle; take_action=4'b0100 for one cycle (bit 35=1).
3. ir=1, 38 shifts of all-zero, dr_update -> jdo=0; take_no_action=4'b0010 for one cycle; take_action=0.
4. ir=0, capture, 20 shifts, dr_update -> short_scan_err=1, jdo unchanged, no pulse. Next capture shows tdo bit 37 = 1. err_clear pulse -> flag 0.
5. ir=3, capture, 12 shifts, ir_update with ir_in=1 -> IDLE, ir_latched=1, busy=0, no pulse, no error.
6. dr_update and dr_capture in the same cycle after 38 shifts -> update processed (pulse next cycle), capture dropped, state IDLE.

Source files
------------

// File: rtl/dbg_scan_pkg.sv
// Shared state encoding and default geometry for the debug scan DR engine.
`timescale 1ns/1ps
package dbg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOADED   = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  localparam int unsigned DBG_IR_WIDTH   = 2;
  localparam int unsigned DBG_DR_WIDTH   = 38;
  localparam int unsigned DBG_ACTION_BIT = 35;

endpackage

// File: rtl/dbg_scan_action_decode.sv
// Registered one-hot decoder: turns a completed update into a one-cycle
// take_action / take_no_action pulse on the channel of the current instruction.
`timescale 1ns/1ps
module dbg_scan_action_decode #(
  parameter int unsigned IR_WIDTH = 2,
  localparam int unsigned NUM_CH  = 2 ** IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                action,
  input  logic                update_ok,
  output logic [NUM_CH-1:0]   take_action,
  output logic [NUM_CH-1:0]   take_no_action
);

  logic [NUM_CH-1:0] onehot;

  // One-hot select of the current channel.
  always_comb begin
    onehot = NUM_CH'(1) << ir;
  end

  // Pulse for exactly one cycle per accepted update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (update_ok && action)  ? onehot : '0;
      take_no_action <= (update_ok && !action) ? onehot : '0;
    end
  end

endmodule

// File: rtl/dbg_scan_dr_engine.sv
// System-clock DR engine: captures a per-instruction status word, shifts it
// out LSB-first while shifting TDI in, and publishes completed scans on jdo.
`timescale 1ns/1ps
module dbg_scan_dr_engine
  import dbg_scan_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = DBG_IR_WIDTH,
  parameter int unsigned DR_WIDTH      = DBG_DR_WIDTH,
  parameter int unsigned ACTION_BIT    = DBG_ACTION_BIT,
  parameter int unsigned STATUS_IN_MSB = 1,
  localparam int unsigned NUM_CH       = 2 ** IR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic                       ir_update,
  input  logic                       dr_capture,
  input  logic                       dr_shift,
  input  logic                       tdi,
  input  logic                       dr_update,
  input  logic [NUM_CH*DR_WIDTH-1:0] capture_data,
  input  logic                       err_clear,
  output logic                       tdo,
  output logic [IR_WIDTH-1:0]        ir_latched,
  output logic [DR_WIDTH-1:0]        jdo,
  output logic [NUM_CH-1:0]          take_action,
  output logic [NUM_CH-1:0]          take_no_action,
  output logic                       short_scan_err,
  output logic                       busy
);

  // Counter saturates at DR_WIDTH+1 so over-long scans stay distinguishable.
  localparam int unsigned CNT_W = $clog2(DR_WIDTH + 2);

  state_t                state, state_nxt;
  logic [DR_WIDTH-1:0]   sr;
  logic [DR_WIDTH-1:0]   cap_word;
  logic [CNT_W-1:0]      shift_cnt;
  logic                  do_load, do_shift, update_ok, err_set;

  assign tdo = sr[0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath strobes; ir_update > dr_update > dr_capture > dr_shift.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    update_ok = 1'b0;
    err_set   = 1'b0;
    if (ir_update) begin
      state_nxt = IDLE;
    end else if (dr_update) begin
      if (state != IDLE) begin
        state_nxt = IDLE;
        if (shift_cnt == CNT_W'(DR_WIDTH)) update_ok = 1'b1;
        else if (shift_cnt != '0)          err_set   = 1'b1;
      end
    end else if (dr_capture) begin
      state_nxt = LOADED;
      do_load   = 1'b1;
    end else if (dr_shift) begin
      if (state != IDLE) begin
        state_nxt = SHIFTING;
        do_shift  = 1'b1;
      end
    end
  end

  // Capture word for the current channel, optionally carrying the error flag in its MSB.
  always_comb begin
    cap_word = capture_data[int'(ir_latched) * DR_WIDTH +: DR_WIDTH];
    if (STATUS_IN_MSB != 0) cap_word[DR_WIDTH-1] = short_scan_err;
  end

  // Shift register, counter, instruction, result word and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr             <= '0;
      shift_cnt      <= '0;
      ir_latched     <= '0;
      jdo            <= '0;
      short_scan_err <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (ir_update) ir_latched <= ir_in;
      if (do_load) begin
        sr        <= cap_word;
        shift_cnt <= '0;
      end else if (do_shift) begin
        sr <= {tdi, sr[DR_WIDTH-1:1]};
        if (shift_cnt != CNT_W'(DR_WIDTH + 1)) shift_cnt <= shift_cnt + CNT_W'(1);
      end
      if (update_ok) jdo <= sr;
      if (err_set)        short_scan_err <= 1'b1;
      else if (err_clear) short_scan_err <= 1'b0;
      busy <= (state_nxt != IDLE);
    end
  end

  dbg_scan_action_decode #(
    .IR_WIDTH (IR_WIDTH)
  ) u_action_decode (
    .clk            (clk),
    .reset          (reset),
    .ir             (ir_latched),
    .action         (sr[ACTION_BIT]),
    .update_ok      (update_ok),
    .take_action    (take_action),
    .take_no_action (take_no_action)
  );

endmodule

// File: tb/tb_dbg_scan_dr_engine.sv
// Bench for dbg_scan_dr_engine: directed scenarios plus random scans checked
// against a scan-level reference model.
`timescale 1ns/1ps
module tb_dbg_scan_dr_engine;

  localparam int unsigned IRW = 2;
  localparam int unsigned DRW = 38;
  localparam int unsigned NCH = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [IRW-1:0]      ir_in = '0;
  logic                ir_update = 1'b0;
  logic                dr_capture = 1'b0;
  logic                dr_shift = 1'b0;
  logic                tdi = 1'b0;
  logic                dr_update = 1'b0;
  logic [NCH*DRW-1:0]  capture_data = '0;
  logic                err_clear = 1'b0;
  logic                tdo;
  logic [IRW-1:0]      ir_latched;
  logic [DRW-1:0]      jdo;
  logic [NCH-1:0]      take_action;
  logic [NCH-1:0]      take_no_action;
  logic                short_scan_err;
  logic                busy;

  always #5 clk = ~clk;

  dbg_scan_dr_engine #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .ACTION_BIT(35), .STATUS_IN_MSB(1)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .ir_update(ir_update),
    .dr_capture(dr_capture), .dr_shift(dr_shift), .tdi(tdi),
    .dr_update(dr_update), .capture_data(capture_data), .err_clear(err_clear),
    .tdo(tdo), .ir_latched(ir_latched), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .short_scan_err(short_scan_err), .busy(busy)
  );

  // Reference model: captured word, bits shifted in so far, and scan length.
  int             m_ir = 0;
  logic [DRW-1:0] m_cap = '0;
  logic [DRW-1:0] m_tdi = '0;
  logic [DRW-1:0] m_jdo = '0;
  int             m_n = 0;
  bit             m_act = 1'b0;
  bit             m_err = 1'b0;
  logic [NCH-1:0] e_ta = '0;
  logic [NCH-1:0] e_tna = '0;

  int ncmp = 0;
  int nfail = 0;

  // Register contents after m_n shifts: remaining capture bits below, TDI bits above.
  function automatic logic [DRW-1:0] mword();
    logic [DRW-1:0] hi;
    hi = (m_n == 0) ? '0 : (m_tdi << (DRW - m_n));
    return (m_cap >> m_n) | hi;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DRW-1:0] w;
    if (m_act && m_n <= int'(DRW)) begin
      w = mword();
      chk({tag, " tdo"}, 64'(tdo), 64'(w[0]));
    end
    chk({tag, " ir_latched"}, 64'(ir_latched), 64'(m_ir));
    chk({tag, " jdo"}, 64'(jdo), 64'(m_jdo));
    chk({tag, " err"}, 64'(short_scan_err), 64'(m_err));
    chk({tag, " busy"}, 64'(busy), 64'(m_act));
    chk({tag, " take_action"}, 64'(take_action), 64'(e_ta));
    chk({tag, " take_no_action"}, 64'(take_no_action), 64'(e_tna));
  endtask

  // One clock of strobes, model update by priority, then check after the edge.
  task automatic op(input bit iu, input int irv, input bit up, input bit cap,
                    input bit sh, input bit t, input bit ec, input string tag);
    bit set;
    logic [DRW-1:0] w;
    @(negedge clk);
    ir_update = iu; ir_in = IRW'(irv); dr_update = up; dr_capture = cap;
    dr_shift = sh; tdi = t; err_clear = ec;
    set = 1'b0; e_ta = '0; e_tna = '0;
    if (iu) begin
      m_ir = irv; m_act = 1'b0;
    end else if (up) begin
      if (m_act) begin
        m_act = 1'b0;
        if (m_n == int'(DRW)) begin
          w = mword();
          m_jdo = w;
          if (w[35]) e_ta = NCH'(1) << m_ir;
          else       e_tna = NCH'(1) << m_ir;
        end else if (m_n != 0) begin
          m_err = 1'b1; set = 1'b1;
        end
      end
    end else if (cap) begin
      m_cap = capture_data[m_ir*DRW +: DRW];
      m_cap[DRW-1] = m_err;
      m_n = 0; m_tdi = '0; m_act = 1'b1;
    end else if (sh) begin
      if (m_act) begin
        if (m_n < int'(DRW)) m_tdi[m_n] = t;
        m_n++;
      end
    end
    if (ec && !set) m_err = 1'b0;
    @(posedge clk);
    #1;
    ir_update = 1'b0; dr_update = 1'b0; dr_capture = 1'b0; dr_shift = 1'b0;
    tdi = 1'b0; err_clear = 1'b0;
    check_all(tag);
  endtask

  task automatic set_ir(input int v);   op(1, v, 0, 0, 0, 0, 0, "ir_update"); endtask
  task automatic capture();             op(0, 0, 0, 1, 0, 0, 0, "capture");   endtask
  task automatic update(input bit ec);  op(0, 0, 1, 0, 0, 0, ec, "update");   endtask
  task automatic idle();                op(0, 0, 0, 0, 0, 0, 0, "idle");      endtask

  task automatic shifts(input int n, input logic [63:0] pat);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 1, pat[i % 64], 0, "shift");
  endtask

  initial begin
    logic [159:0] rnd;
    int len;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    capture_data = rnd[NCH*DRW-1:0];
    capture_data[2*DRW +: DRW] = 38'h2A_5555_AAAA;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset_state");

    // Full scan on channel 2 with action bit set.
    set_ir(2);
    capture();
    shifts(38, 64'h08_0000_0001);
    update(0);
    idle();

    // Full all-zero scan on channel 1: no-action pulse.
    set_ir(1);
    capture();
    shifts(38, 64'h0);
    update(0);
    idle();

    // Short scan on channel 0 sets the sticky error, shown in the next capture MSB.
    set_ir(0);
    capture();
    shifts(20, {$urandom, $urandom});
    update(0);
    capture();
    shifts(38, {$urandom, $urandom});
    update(0);
    op(0, 0, 0, 0, 0, 0, 1, "err_clear");

    // IR change aborts an in-flight scan.
    set_ir(3);
    capture();
    shifts(12, {$urandom, $urandom});
    set_ir(1);
    update(0);

    // Update and capture together: update wins, capture dropped.
    capture();
    shifts(38, {$urandom, $urandom});
    op(0, 0, 1, 1, 0, 0, 0, "update_and_capture");
    idle();

    // Read-only scan and stray strobes in IDLE.
    capture();
    update(0);
    op(0, 0, 0, 0, 1, 1, 0, "idle_shift");
    update(0);

    // Random scans: full, zero-length, short/over-long, aborted, with err_clear.
    for (int k = 0; k < 30; k++) begin
      set_ir(int'($urandom_range(0, 3)));
      capture();
      case ($urandom_range(0, 3))
        0: len = 0;
        1, 2: len = 38;
        default: len = int'($urandom_range(1, 40));
      endcase
      shifts(len, {$urandom, $urandom});
      if ($urandom_range(0, 5) == 0) set_ir(int'($urandom_range(0, 3)));
      else update(1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-shift clears everything immediately.
    set_ir(2);
    capture();
    shifts(20, {$urandom, $urandom});
    update(0);
    capture();
    shifts(10, {$urandom, $urandom});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    m_ir = 0; m_jdo = '0; m_err = 1'b0; m_act = 1'b0; e_ta = '0; e_tna = '0;
    chk("async_reset tdo", 64'(tdo), 64'(0));
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    update(0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
